// File: rtl/handshaked_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : handshaked_rr_arbiter_if
// Brief    : Requester-side and downstream handshake bundle for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface handshaked_rr_arbiter_if #(
    parameter int DATA_WIDTH = 2,
    parameter int INPUTS     = 4
);
    logic [INPUTS*DATA_WIDTH-1:0] din_data;
    logic [INPUTS-1:0]            din_last;
    logic [INPUTS-1:0]            din_vld;
    logic [INPUTS-1:0]            din_rd;
    logic [DATA_WIDTH-1:0]        dout_data;
    logic                         dout_last;
    logic [2:0]                   dout_src;
    logic                         dout_vld;
    logic                         dout_rd;

    modport slave (
        input  din_data, din_last, din_vld, dout_rd,
        output din_rd, dout_data, dout_last, dout_src, dout_vld
    );

    modport master (
        output din_data, din_last, din_vld, dout_rd,
        input  din_rd, dout_data, dout_last, dout_src, dout_vld
    );
endinterface
`default_nettype wire

// File: rtl/handshaked_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : handshaked_rr_arbiter
// Brief    : Round-robin N:1 valid/ready arbiter with a one-beat output register.
//            Define HANDSHAKED_RR_ARBITER_PKT_LOCK_EN to hold the grant for a
//            whole packet (until din_last).
// Revision : 1.0 - initial release
// ============================================================================
module handshaked_rr_arbiter #(
    parameter int DATA_WIDTH = 2,
    parameter int INPUTS     = 4
) (
    input  wire                    clk,
    input  wire                    rst,
    handshaked_rr_arbiter_if.slave bus
);
    localparam int            PW        = $clog2(INPUTS);
    localparam logic [PW-1:0] C_PTR_RST = PW'(INPUTS - 1);

    logic [PW-1:0]         r_ptr;
    logic                  r_dout_vld;
    logic [DATA_WIDTH-1:0] r_dout_data;
    logic                  r_dout_last;
    logic [2:0]            r_dout_src;

    logic [INPUTS-1:0]     w_elig;
    logic [INPUTS-1:0]     w_din_rd;
    logic [PW-1:0]         w_gnt;
    logic                  w_gnt_vld;
    logic                  w_load_en;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_last;

`ifdef HANDSHAKED_RR_ARBITER_PKT_LOCK_EN
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_lock;

    // While a packet is in flight only its owner may be granted.
    always_comb begin
        w_elig = '0;
        if (r_state == S_LOCKED) begin
            w_elig[r_lock] = bus.din_vld[r_lock];
        end else begin
            w_elig = bus.din_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lock  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer && !w_sel_last) begin
                        r_state <= S_LOCKED;
                        r_lock  <= w_gnt;
                    end
                end
                S_LOCKED: begin
                    if (w_xfer && w_sel_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_elig = bus.din_vld;
`endif

    // Two passes: indices above the pointer first, then wrap to the low ones.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (!w_gnt_vld && (PW'(i) > r_ptr) && w_elig[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = PW'(i);
            end
        end
        for (int i = 0; i < INPUTS; i++) begin
            if (!w_gnt_vld && (PW'(i) <= r_ptr) && w_elig[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = PW'(i);
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            if (w_gnt == PW'(i)) begin
                w_sel_data = bus.din_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_last = bus.din_last[i];
            end
        end
    end

    assign w_load_en = !r_dout_vld || bus.dout_rd;
    assign w_xfer    = !rst && w_load_en && w_gnt_vld;

    always_comb begin
        w_din_rd = '0;
        if (w_xfer) begin
            w_din_rd[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= C_PTR_RST;
            r_dout_vld  <= 1'b0;
            r_dout_data <= '0;
            r_dout_last <= 1'b0;
            r_dout_src  <= '0;
        end else if (w_xfer) begin
            r_ptr       <= w_gnt;
            r_dout_vld  <= 1'b1;
            r_dout_data <= w_sel_data;
            r_dout_last <= w_sel_last;
            r_dout_src  <= 3'(w_gnt);
        end else if (bus.dout_rd) begin
            r_dout_vld  <= 1'b0;
        end
    end

    assign bus.din_rd    = w_din_rd;
    assign bus.dout_vld  = r_dout_vld;
    assign bus.dout_data = r_dout_data;
    assign bus.dout_last = r_dout_last;
    assign bus.dout_src  = r_dout_src;
endmodule
`default_nettype wire

// File: tb/tb_handshaked_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshaked_rr_arbiter
// Brief    : Self-checking bench for handshaked_rr_arbiter (4x2 and 2x3 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_handshaked_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    handshaked_rr_arbiter_if #(.DATA_WIDTH(2), .INPUTS(4)) bus4 ();
    handshaked_rr_arbiter_if #(.DATA_WIDTH(3), .INPUTS(2)) bus2 ();

    handshaked_rr_arbiter #(.DATA_WIDTH(2), .INPUTS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    handshaked_rr_arbiter #(.DATA_WIDTH(3), .INPUTS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    // Reference model of the 4-input instance: output register plus pointer.
    int         m_ptr;
    logic       m_vld;
    logic [1:0] m_data;
    logic       m_last;
    int         m_src;
`ifdef HANDSHAKED_RR_ARBITER_PKT_LOCK_EN
    logic       m_locked;
    int         m_lock;
`endif

    function automatic int model_grant(input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
`ifdef HANDSHAKED_RR_ARBITER_PKT_LOCK_EN
            if (m_locked && idx != m_lock) continue;
`endif
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_rd(input logic r, input logic [3:0] v, input logic dr);
        logic [3:0] res;
        int         g;
        res = '0;
        g   = model_grant(v);
        if (!r && g >= 0 && (!m_vld || dr)) res[g] = 1'b1;
        return res;
    endfunction

    task automatic model_advance();
        int g;
        if (rst) begin
            m_ptr = 3; m_vld = 1'b0; m_data = '0; m_last = 1'b0; m_src = 0;
`ifdef HANDSHAKED_RR_ARBITER_PKT_LOCK_EN
            m_locked = 1'b0; m_lock = 0;
`endif
        end else begin
            g = model_grant(bus4.din_vld);
            if (g >= 0 && (!m_vld || bus4.dout_rd)) begin
                m_vld  = 1'b1;
                m_data = bus4.din_data[g*2 +: 2];
                m_last = bus4.din_last[g];
                m_src  = g;
                m_ptr  = g;
`ifdef HANDSHAKED_RR_ARBITER_PKT_LOCK_EN
                if (!m_locked && !bus4.din_last[g]) begin
                    m_locked = 1'b1; m_lock = g;
                end else if (m_locked && bus4.din_last[g]) begin
                    m_locked = 1'b0;
                end
`endif
            end else if (bus4.dout_rd) begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic drive4(input logic r, input logic [3:0] v, input logic [7:0] d,
                          input logic [3:0] l, input logic dr);
        rst = r; bus4.din_vld = v; bus4.din_data = d; bus4.din_last = l; bus4.dout_rd = dr;
    endtask

    task automatic tick4();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive4(1'b1, 4'h0, 8'h00, 4'h0, 1'b0);
        tick4();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_rd;
        for (int c = 0; c < 2; c++) begin
            drive4(1'b1, 4'hF, 8'($urandom), 4'hF, 1'b1);
            @(negedge clk);
            exp_rd = model_rd(rst, bus4.din_vld, bus4.dout_rd);
            n_checks++;
            if (bus4.din_rd !== exp_rd) $display("FAIL reset_din_rd got=%b exp=%b", bus4.din_rd, exp_rd);
            else n_pass++;
            tick4();
        end
        drive4(1'b0, 4'h0, 8'h00, 4'h0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (bus4.dout_vld !== 1'b0 || bus4.dout_data !== 2'b00 || bus4.dout_last !== 1'b0 || bus4.dout_src !== 3'd0)
            $display("FAIL reset_outputs got vld=%b data=%b last=%b src=%0d exp all zero",
                     bus4.dout_vld, bus4.dout_data, bus4.dout_last, bus4.dout_src);
        else n_pass++;
        tick4();
    endtask

    task automatic test_rotation();
        logic [3:0] exp_rd;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive4(1'b0, 4'hF, 8'($urandom), 4'hF, 1'b1);
            @(negedge clk);
            exp_rd = model_rd(rst, bus4.din_vld, bus4.dout_rd);
            n_checks++;
            if (bus4.din_rd !== exp_rd) $display("FAIL rot_din_rd c=%0d got=%b exp=%b", c, bus4.din_rd, exp_rd);
            else n_pass++;
            n_checks++;
            if (bus4.dout_vld !== m_vld || (m_vld && {bus4.dout_src, bus4.dout_data, bus4.dout_last} !== {3'(m_src), m_data, m_last}))
                $display("FAIL rot_dout c=%0d got vld=%b src=%0d data=%b exp vld=%b src=%0d data=%b",
                         c, bus4.dout_vld, bus4.dout_src, bus4.dout_data, m_vld, m_src, m_data);
            else n_pass++;
            if (c >= 1) begin
                n_checks++;
                if (bus4.dout_vld !== 1'b1 || bus4.dout_src !== 3'((c - 1) % 4))
                    $display("FAIL rot_sequence c=%0d got vld=%b src=%0d exp vld=1 src=%0d",
                             c, bus4.dout_vld, bus4.dout_src, (c - 1) % 4);
                else n_pass++;
            end
            tick4();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_rd;
        int         acc;
        acc = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive4(1'b0, (c < 4) ? 4'b0100 : 4'b0000, 8'b0010_0000, 4'b0100, (c >= 4));
            @(negedge clk);
            exp_rd = model_rd(rst, bus4.din_vld, bus4.dout_rd);
            n_checks++;
            if (bus4.din_rd !== exp_rd) $display("FAIL bp_din_rd c=%0d got=%b exp=%b", c, bus4.din_rd, exp_rd);
            else n_pass++;
            if (c >= 1 && c <= 4) begin
                n_checks++;
                if (bus4.dout_vld !== 1'b1 || bus4.dout_data !== 2'b10 || bus4.dout_src !== 3'd2)
                    $display("FAIL bp_hold c=%0d got vld=%b data=%b src=%0d exp vld=1 data=10 src=2",
                             c, bus4.dout_vld, bus4.dout_data, bus4.dout_src);
                else n_pass++;
            end
            if (c == 5) begin
                n_checks++;
                if (bus4.dout_vld !== 1'b0) $display("FAIL bp_drain got vld=%b exp=0", bus4.dout_vld);
                else n_pass++;
            end
            if (bus4.din_rd[2]) acc++;
            tick4();
        end
        n_checks++;
        if (acc != 1) $display("FAIL bp_accept_once got=%0d exp=1", acc);
        else n_pass++;
    endtask

    task automatic test_packet();
        logic [3:0] exp_rd;
        int         b1;
        int         exp_tab[5];
`ifdef HANDSHAKED_RR_ARBITER_PKT_LOCK_EN
        exp_tab = '{1, 1, 1, 0, 0};
`else
        exp_tab = '{1, 0, 1, 0, 1};
`endif
        do_reset();
        drive4(1'b0, 4'b0001, 8'h00, 4'b0001, 1'b1);
        tick4();
        b1 = 0;
        for (int c = 0; c < 6; c++) begin
            drive4(1'b0, {2'b00, (b1 < 3), 1'b1}, {4'h0, 2'(b1), 2'b11}, {2'b00, (b1 == 2), 1'b1}, 1'b1);
            @(negedge clk);
            exp_rd = model_rd(rst, bus4.din_vld, bus4.dout_rd);
            n_checks++;
            if (bus4.din_rd !== exp_rd) $display("FAIL pkt_din_rd c=%0d got=%b exp=%b", c, bus4.din_rd, exp_rd);
            else n_pass++;
            if (c >= 1) begin
                n_checks++;
                if (bus4.dout_vld !== 1'b1 || bus4.dout_src !== 3'(exp_tab[c-1]))
                    $display("FAIL pkt_src c=%0d got vld=%b src=%0d exp src=%0d",
                             c, bus4.dout_vld, bus4.dout_src, exp_tab[c-1]);
                else n_pass++;
            end
            if (bus4.din_rd[1]) b1++;
            tick4();
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [3:0] exp_rd;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0, 1:    drive4(1'b0, 4'b0100, 8'b0001_0000, 4'b0000, 1'b0);
                2:       drive4(1'b1, 4'b0100, 8'b0001_0000, 4'b0000, 1'b0);
                3:       drive4(1'b0, 4'hF, 8'b10_01_11_01, 4'hF, 1'b1);
                default: drive4(1'b0, 4'h0, 8'h00, 4'h0, 1'b1);
            endcase
            @(negedge clk);
            exp_rd = model_rd(rst, bus4.din_vld, bus4.dout_rd);
            n_checks++;
            if (bus4.din_rd !== exp_rd) $display("FAIL mid_din_rd c=%0d got=%b exp=%b", c, bus4.din_rd, exp_rd);
            else n_pass++;
            n_checks++;
            if (bus4.dout_vld !== m_vld || (m_vld && {bus4.dout_src, bus4.dout_data} !== {3'(m_src), m_data}))
                $display("FAIL mid_dout c=%0d got vld=%b src=%0d exp vld=%b src=%0d",
                         c, bus4.dout_vld, bus4.dout_src, m_vld, m_src);
            else n_pass++;
            if (c == 3) begin
                n_checks++;
                if (bus4.dout_vld !== 1'b0 || bus4.din_rd !== 4'b0001)
                    $display("FAIL mid_after_rst got vld=%b din_rd=%b exp vld=0 din_rd=0001", bus4.dout_vld, bus4.din_rd);
                else n_pass++;
            end
            if (c == 4) begin
                n_checks++;
                if (bus4.dout_src !== 3'd0 || bus4.dout_data !== 2'b01)
                    $display("FAIL mid_first_grant got src=%0d data=%b exp src=0 data=01", bus4.dout_src, bus4.dout_data);
                else n_pass++;
            end
            tick4();
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_rd;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            drive4(($urandom % 64) == 0, 4'($urandom), 8'($urandom), 4'($urandom), ($urandom % 4) != 0);
            @(negedge clk);
            exp_rd = model_rd(rst, bus4.din_vld, bus4.dout_rd);
            n_checks++;
            if (bus4.din_rd !== exp_rd) $display("FAIL rnd_din_rd c=%0d got=%b exp=%b", c, bus4.din_rd, exp_rd);
            else n_pass++;
            n_checks++;
            if (bus4.dout_vld !== m_vld || (m_vld && {bus4.dout_src, bus4.dout_data, bus4.dout_last} !== {3'(m_src), m_data, m_last}))
                $display("FAIL rnd_dout c=%0d got vld=%b src=%0d data=%b last=%b exp vld=%b src=%0d data=%b last=%b",
                         c, bus4.dout_vld, bus4.dout_src, bus4.dout_data, bus4.dout_last, m_vld, m_src, m_data, m_last);
            else n_pass++;
            tick4();
        end
        rst = 1'b0;
    endtask

    // Each requester streams sequence numbers; every one must emerge exactly once, in order.
    task automatic test_two_inputs();
        int seq[2];
        int nxt[2];
        int s;
        int prev_src;
        seq = '{0, 0}; nxt = '{0, 0}; prev_src = -1;
        rst = 1'b1;
        bus2.din_vld = 2'b00; bus2.dout_rd = 1'b0; bus2.din_data = '0; bus2.din_last = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus2.din_vld  = (c < 350) ? 2'b11 : 2'b00;
            bus2.din_data = {3'(seq[1]), 3'(seq[0])};
            bus2.din_last = 2'($urandom);
            bus2.dout_rd  = (c >= 350) ? 1'b1 : 1'($urandom);
            @(negedge clk);
            n_checks++;
            if ($countones(bus2.din_rd) > 1 || (bus2.din_rd & ~bus2.din_vld) != 2'b00)
                $display("FAIL two_din_rd c=%0d got=%b vld=%b exp at most one granted valid", c, bus2.din_rd, bus2.din_vld);
            else n_pass++;
            if (bus2.dout_vld && bus2.dout_rd) begin
                s = int'(bus2.dout_src);
                n_checks++;
                if (s > 1 || bus2.dout_data !== 3'(nxt[s > 1 ? 0 : s]))
                    $display("FAIL two_order c=%0d src=%0d got data=%0d exp data=%0d",
                             c, s, bus2.dout_data, nxt[s > 1 ? 0 : s]);
                else n_pass++;
`ifndef HANDSHAKED_RR_ARBITER_PKT_LOCK_EN
                if (prev_src >= 0 && c < 350) begin
                    n_checks++;
                    if (s == prev_src) $display("FAIL two_alternate c=%0d got src=%0d exp src!=%0d", c, s, prev_src);
                    else n_pass++;
                end
`endif
                prev_src = s;
                if (s <= 1) nxt[s]++;
            end
            for (int i = 0; i < 2; i++) if (bus2.din_rd[i]) seq[i]++;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (nxt[i] != seq[i] || seq[i] == 0)
                $display("FAIL two_conserve req=%0d got out=%0d exp out=%0d (nonzero)", i, nxt[i], seq[i]);
            else n_pass++;
        end
    endtask

    initial begin
        bus4.din_vld = '0; bus4.din_data = '0; bus4.din_last = '0; bus4.dout_rd = 1'b0;
        bus2.din_vld = '0; bus2.din_data = '0; bus2.din_last = '0; bus2.dout_rd = 1'b0;
        m_ptr = 3; m_vld = 1'b0; m_data = '0; m_last = 1'b0; m_src = 0;
`ifdef HANDSHAKED_RR_ARBITER_PKT_LOCK_EN
        m_locked = 1'b0; m_lock = 0;
`endif
        #1;
        test_reset();
        test_rotation();
        test_backpressure();
        test_packet();
        test_reset_mid_packet();
        test_random();
        test_two_inputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
